// File: rtl/cpu_pkg.sv
// Shared types and constants for the ALU sequencer: FSM states, instruction
// field layout and the LDI opcode.
package cpu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DECODE = 2'd1,
        ST_EXEC   = 2'd2,
        ST_WB     = 2'd3
    } state_t;

    localparam logic [3:0] OP_LDI = 4'hF;

    localparam int INSTR_W = 16;
    localparam int OPC_MSB = 15;
    localparam int OPC_LSB = 12;
    localparam int RD_MSB  = 11;
    localparam int RD_LSB  = 9;
    localparam int RS1_MSB = 8;
    localparam int RS1_LSB = 6;
    localparam int RS2_MSB = 5;
    localparam int RS2_LSB = 3;
    localparam int CIN_BIT = 1;
    localparam int BIN_BIT = 0;
    localparam int IMM_W   = 9;

    // Packed so that a raw instruction word casts straight onto the fields.
    typedef struct packed {
        logic [3:0] opcode;
        logic [2:0] rd;
        logic [2:0] rs1;
        logic [2:0] rs2;
        logic       rsvd;
        logic       cin;
        logic       bin;
    } instr_t;

    // LDI immediate is the low nine bits, overlapping rs1/rs2/flag fields.
    function automatic logic [IMM_W-1:0] ldi_imm(input instr_t ins);
        return {ins.rs1, ins.rs2, ins.rsvd, ins.cin, ins.bin};
    endfunction

endpackage

// File: rtl/cpu_regfile.sv
// 8-entry register file: two operand read ports plus a debug read port, one
// synchronous write port; r0 is hard-wired to zero.
module cpu_regfile #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [2:0]       rs1_addr,
    output logic [WIDTH-1:0] rs1_data,
    input  logic [2:0]       rs2_addr,
    output logic [WIDTH-1:0] rs2_data,
    input  logic [2:0]       dbg_addr,
    output logic [WIDTH-1:0] dbg_data,
    input  logic             wr_en,
    input  logic [2:0]       wr_addr,
    input  logic [WIDTH-1:0] wr_data
);

    logic [WIDTH-1:0]            regs [8];
    logic [2:0][2:0]             rd_addr;
    logic [2:0][WIDTH-1:0]       rd_data;

    // Entry 0 is cleared at reset and never written, so it always reads 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_en && (wr_addr != 3'd0)) begin
            regs[wr_addr] <= wr_data;
        end
    end

    assign rd_addr[0] = rs1_addr;
    assign rd_addr[1] = rs2_addr;
    assign rd_addr[2] = dbg_addr;

    for (genvar gi = 0; gi < 3; gi++) begin : g_rd_port
        assign rd_data[gi] = (rd_addr[gi] == 3'd0) ? '0 : regs[rd_addr[gi]];
    end

    assign rs1_data = rd_data[0];
    assign rs2_data = rd_data[1];
    assign dbg_data = rd_data[2];

endmodule

// File: rtl/alu_seq_ctrl.sv
// Multi-cycle sequencer for the 16-bit combinational ALU: accepts one
// instruction, drives the ALU from registers and writes the result back.
module alu_seq_ctrl
    import cpu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               instr_valid,
    input  logic [15:0]        instr,
    output logic               instr_ready,
    output logic [3:0]         alu_op,
    output logic [WIDTH-1:0]   alu_a,
    output logic [WIDTH-1:0]   alu_b,
    output logic               alu_cin,
    output logic               alu_bin,
    input  logic [WIDTH-1:0]   alu_result,
    output logic               done,
    output logic [WIDTH-1:0]   done_data,
    input  logic [2:0]         dbg_addr,
    output logic [WIDTH-1:0]   dbg_data
);

    state_t             state_reg;
    state_t             state_next;
    instr_t             instr_reg;
    logic               instr_ready_reg;
    logic               done_reg;
    logic [WIDTH-1:0]   done_data_reg;
    logic [3:0]         alu_op_reg;
    logic [WIDTH-1:0]   alu_a_reg;
    logic [WIDTH-1:0]   alu_b_reg;
    logic               alu_cin_reg;
    logic               alu_bin_reg;

    logic [WIDTH-1:0]   rs1_data;
    logic [WIDTH-1:0]   rs2_data;
    logic               accept;
    logic               is_ldi;
    logic               wr_en;

    assign accept = instr_valid && instr_ready_reg;
    assign is_ldi = (instr_reg.opcode == OP_LDI);
    assign wr_en  = (state_reg == ST_WB);

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:   if (accept) state_next = ST_DECODE;
            ST_DECODE: state_next = is_ldi ? ST_WB : ST_EXEC;
            ST_EXEC:   state_next = ST_WB;
            ST_WB:     state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    // Ready and done are derived from the next state so both are plain flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= ST_IDLE;
            instr_ready_reg <= 1'b1;
            done_reg        <= 1'b0;
        end else begin
            state_reg       <= state_next;
            instr_ready_reg <= (state_next == ST_IDLE);
            done_reg        <= (state_next == ST_WB);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_reg <= '0;
        end else if (accept) begin
            instr_reg <= instr_t'(instr);
        end
    end

    // ALU operands change only when leaving DECODE for EXEC.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_op_reg  <= '0;
            alu_a_reg   <= '0;
            alu_b_reg   <= '0;
            alu_cin_reg <= 1'b0;
            alu_bin_reg <= 1'b0;
        end else if ((state_reg == ST_DECODE) && !is_ldi) begin
            alu_op_reg  <= instr_reg.opcode;
            alu_a_reg   <= rs1_data;
            alu_b_reg   <= rs2_data;
            alu_cin_reg <= instr_reg.cin;
            alu_bin_reg <= instr_reg.bin;
        end
    end

    // done_data doubles as the write-back register and holds after retire.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done_data_reg <= '0;
        end else if ((state_reg == ST_DECODE) && is_ldi) begin
            done_data_reg <= WIDTH'(ldi_imm(instr_reg));
        end else if (state_reg == ST_EXEC) begin
            done_data_reg <= alu_result;
        end
    end

    cpu_regfile #(
        .WIDTH (WIDTH)
    ) u_regfile (
        .clk      (clk),
        .rst_n    (rst_n),
        .rs1_addr (instr_reg.rs1),
        .rs1_data (rs1_data),
        .rs2_addr (instr_reg.rs2),
        .rs2_data (rs2_data),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data),
        .wr_en    (wr_en),
        .wr_addr  (instr_reg.rd),
        .wr_data  (done_data_reg)
    );

    assign instr_ready = instr_ready_reg;
    assign done        = done_reg;
    assign done_data   = done_data_reg;
    assign alu_op      = alu_op_reg;
    assign alu_a       = alu_a_reg;
    assign alu_b       = alu_b_reg;
    assign alu_cin     = alu_cin_reg;
    assign alu_bin     = alu_bin_reg;

endmodule
